// File: rtl/da_fir_sequencer_if.sv
// Handshake bundle for da_fir_sequencer: sample input, result output and
// coefficient write port.
interface da_fir_sequencer_if #(
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int OUT_W = DW + CW + 2
);
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             cfg_we;
   logic             cfg_ready;
   logic [1:0]       cfg_addr;
   logic [CW-1:0]    cfg_data;

   modport master (
      output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_data, cfg_ready
   );

   modport slave (
      input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
      output in_ready, out_valid, out_data, cfg_ready
   );
endinterface

// File: rtl/da_fir_sequencer.sv
// Bit-serial distributed-arithmetic 4-tap FIR with sequential LUT rebuild.
// Optional output clamp enabled by defining DA_FIR_SAT_EN (default: wrap).
//
// state | meaning
// IDLE  | waiting for a sample or a coefficient write (write wins)
// BUILD | rewriting LUT entries 0..15, one per cycle
// RUN   | one bit-plane per cycle, sign plane last
// OUT   | result held until out_ready; may take the next sample same cycle
module da_fir_sequencer #(
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int OUT_W = DW + CW + 2
) (
   input logic               clk,
   input logic               rst,
   da_fir_sequencer_if.slave bus
);
   localparam int AW    = DW + CW + 2;
   localparam int LW    = CW + 2;
   localparam int EW    = (AW > OUT_W) ? AW : OUT_W;
   localparam int CNT_W = $clog2((DW > 16) ? DW : 16);
   localparam int BW    = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, BUILD, RUN, OUT} state_t;
   state_t state, state_nxt;

   logic                    rdy_q;
   logic [CNT_W-1:0]        cnt;
   logic signed [DW-1:0]    x    [4];
   logic signed [CW-1:0]    coef [4];
   logic signed [LW-1:0]    lut  [16];
   logic signed [AW-1:0]    acc;
   logic [OUT_W-1:0]        out_q;

   logic                    in_hs, cfg_hs;
   logic [BW-1:0]           bit_idx;
   logic [3:0]              lut_addr, build_idx;
   logic signed [LW-1:0]    build_val;
   logic signed [AW-1:0]    term, acc_nxt;
   logic signed [EW-1:0]    acc_ext;
   logic [OUT_W-1:0]        res;

   assign in_hs        = bus.in_valid & bus.in_ready;
   assign cfg_hs       = bus.cfg_we & bus.cfg_ready;
   assign bus.out_data = out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.cfg_ready = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.cfg_ready = rdy_q;
            bus.in_ready  = rdy_q & ~bus.cfg_we;
            if (rdy_q && bus.cfg_we)        state_nxt = BUILD;
            else if (rdy_q && bus.in_valid) state_nxt = RUN;
         end
         BUILD: if (cnt == '0) state_nxt = IDLE;
         RUN:   if (cnt == '0) state_nxt = OUT;
         OUT: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
            if (bus.out_ready) state_nxt = bus.in_valid ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cnt counts down in both BUILD and RUN; the index it stands for is derived here.
   assign bit_idx   = BW'(DW - 1) - BW'(cnt);
   assign build_idx = 4'(CNT_W'(15) - cnt);
   assign lut_addr  = {x[3][bit_idx], x[2][bit_idx], x[1][bit_idx], x[0][bit_idx]};
   assign build_val = (build_idx[0] ? LW'(coef[0]) : {LW{1'b0}})
                    + (build_idx[1] ? LW'(coef[1]) : {LW{1'b0}})
                    + (build_idx[2] ? LW'(coef[2]) : {LW{1'b0}})
                    + (build_idx[3] ? LW'(coef[3]) : {LW{1'b0}});
   assign term      = AW'(lut[lut_addr]) <<< bit_idx;
   assign acc_nxt   = (bit_idx == BW'(DW - 1)) ? acc - term : acc + term;
   assign acc_ext   = EW'(acc_nxt);

`ifdef DA_FIR_SAT_EN
   logic signed [EW-1:0] sat_max, sat_min;
   assign sat_max = EW'({1'b0, {(OUT_W-1){1'b1}}});
   assign sat_min = ~sat_max;
   always_comb begin
      res = acc_ext[OUT_W-1:0];
      if (acc_ext > sat_max)      res = sat_max[OUT_W-1:0];
      else if (acc_ext < sat_min) res = sat_min[OUT_W-1:0];
   end
`else
   assign res = acc_ext[OUT_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         out_q <= '0;
         for (int k = 0; k < 4; k++) begin
            x[k]    <= '0;
            coef[k] <= CW'(1);
         end
         for (int i = 0; i < 16; i++) lut[i] <= LW'($countones(i));
      end else begin
         rdy_q <= 1'b1;
         if (in_hs) begin
            x[3] <= x[2];
            x[2] <= x[1];
            x[1] <= x[0];
            x[0] <= bus.in_data;
         end
         case (state)
            IDLE: begin
               if (cfg_hs) begin
                  coef[bus.cfg_addr] <= bus.cfg_data;
                  cnt                <= CNT_W'(15);
               end else if (in_hs) begin
                  cnt <= CNT_W'(DW - 1);
                  acc <= '0;
               end
            end
            BUILD: begin
               lut[build_idx] <= build_val;
               cnt            <= cnt - CNT_W'(1);
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) out_q <= res;
            end
            OUT: begin
               if (in_hs) begin
                  cnt <= CNT_W'(DW - 1);
                  acc <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_da_fir_sequencer.sv
// Directed bench for da_fir_sequencer; a second 11-bit-output instance
// shadows the main one to cover wrap vs DA_FIR_SAT_EN clamping.
module tb_da_fir_sequencer;
   localparam int DW    = 8;
   localparam int CW    = 8;
   localparam int OUT_W = DW + CW + 2;
   localparam int OW11  = 11;
   localparam int EXP11 =
`ifdef DA_FIR_SAT_EN
      1023;
`else
      0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   da_fir_sequencer_if #(.DW(DW), .CW(CW), .OUT_W(OUT_W)) bus ();
   da_fir_sequencer_if #(.DW(DW), .CW(CW), .OUT_W(OW11))  bus11 ();

   da_fir_sequencer #(.DW(DW), .CW(CW), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   da_fir_sequencer #(.DW(DW), .CW(CW), .OUT_W(OW11)) dut11 (
      .clk(clk), .rst(rst), .bus(bus11)
   );

   assign bus11.in_valid  = bus.in_valid;
   assign bus11.in_data   = bus.in_data;
   assign bus11.out_ready = bus.out_ready;
   assign bus11.cfg_we    = bus.cfg_we;
   assign bus11.cfg_addr  = bus.cfg_addr;
   assign bus11.cfg_data  = bus.cfg_data;

   int n_tests = 0;
   int n_fail  = 0;
   int last_out11;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      #1;
      chk({tag, ".rst_in_ready"},  int'(bus.in_ready), 0);
      chk({tag, ".rst_cfg_ready"}, int'(bus.cfg_ready), 0);
      chk({tag, ".rst_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, ".rst_out_data"},  int'(bus.out_data), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk({tag, ".post_in_ready"},  int'(bus.in_ready), 1);
      chk({tag, ".post_cfg_ready"}, int'(bus.cfg_ready), 1);
   endtask

   // Push one sample, measure accept-to-valid latency, check result, consume it.
   task automatic send(input int x, input string tag, input int exp);
      int n = 0;
      while (!bus.in_ready && n < 40) begin tick(); n++; end
      chk({tag, ".in_ready"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = x[DW-1:0];
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
      chk({tag, ".lat"},  n, DW);
      chk({tag, ".data"}, int'($signed(bus.out_data)), exp);
      last_out11 = int'($signed(bus11.out_data));
      tick();
   endtask

   task automatic cfg_write(input int addr, input int val);
      int n    = 0;
      int leak = 0;
      while (!bus.cfg_ready && n < 40) begin tick(); n++; end
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr[1:0];
      bus.cfg_data = val[CW-1:0];
      #1;
      chk("cfg.in_ready_during_we", int'(bus.in_ready), 0);
      tick();
      bus.cfg_we = 1'b0;
      n = 0;
      while (!bus.cfg_ready && n < 40) begin
         if (bus.in_ready) leak = 1;
         tick();
         n++;
      end
      chk("cfg.build_cycles", n, 16);
      chk("cfg.in_blocked",   leak, 0);
   endtask

   initial begin
      int n;
      int bad;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      #2;

      // default coefficients all 1: output is the running 4-sample sum
      do_reset("t1");
      send(10, "t1.s0", 10);
      send(20, "t1.s1", 30);
      send(30, "t1.s2", 60);
      send(40, "t1.s3", 100);

      do_reset("t2");
      send(-128, "t2.s0", -128);
      send(-128, "t2.s1", -256);
      send(-128, "t2.s2", -384);
      send(-128, "t2.s3", -512);

      do_reset("t3");
      cfg_write(0, 3);
      cfg_write(1, -2);
      cfg_write(2, 0);
      cfg_write(3, 127);
      send(1, "t3.s0", 3);
      send(2, "t3.s1", 4);
      send(0, "t3.s2", -4);
      send(0, "t3.s3", 127);

      // back-pressure, then simultaneous output and input handshake
      do_reset("t5");
      bus.out_ready = 1'b0;
      chk("bp.in_ready", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd7;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
      chk("bp.lat0",  n, DW);
      chk("bp.data0", int'($signed(bus.out_data)), 7);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_data !== 18'd7 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
      end
      chk("bp.hold", bad, 0);
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'd3;
      bus.out_ready = 1'b1;
      #1;
      chk("bp.in_ready_follow", int'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp.out_valid_drop", int'(bus.out_valid), 0);
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
      chk("bp.lat1",  n, DW);
      chk("bp.data1", int'($signed(bus.out_data)), 10);
      tick();

      // most negative coefficients and samples: full-width result / 11-bit wrap or clamp
      do_reset("t4");
      for (int k = 0; k < 4; k++) cfg_write(k, -128);
      send(-128, "t4.s0", 16384);
      send(-128, "t4.s1", 32768);
      send(-128, "t4.s2", 49152);
      send(-128, "t4.s3", 65536);
      chk("t4.out11", last_out11, EXP11);

      // reset on the 4th RUN cycle discards result, history and coefficients
      n = 0;
      while (!bus.in_ready && n < 40) begin tick(); n++; end
      chk("t6.in_ready", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd9;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      do_reset("t6");
      send(5, "t6.s0", 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
